// File: rtl/chan_550_threshold_trigger.sv
// Threshold-crossing trigger that captures 2^CAP_AW samples into a buffer; write port registered, 1-cycle latency.
// No backpressure: every valid sample in CAPTURE is written, samples outside ARMED/CAPTURE are dropped.
module chan_550_threshold_trigger #(
  parameter int DATA_W = 16,
  parameter int CAP_AW = 10
) (
  input  logic                     user_clk,
  input  logic                     user_rst_n,
  input  logic [31:0]              threshold,
  input  logic                     arm,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_valid,
  output logic                     cap_we,
  output logic [CAP_AW-1:0]        cap_addr,
  output logic [DATA_W-1:0]        cap_data,
  output logic                     armed,
  output logic                     done,
  output logic [15:0]              trig_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  localparam logic [CAP_AW-1:0] ADDR_ONE  = 1;
  localparam logic [CAP_AW-1:0] ADDR_LAST = '1;

  state_t                     state;
  logic [31:0]                thr_q;
  logic                       prev_cmp;
  logic signed [DATA_W-1:0]   level;
  logic                       cmp;
  logic                       unused_thr;

  // Only the latched copy is ever compared, so threshold writes during a run are harmless.
  assign level      = DATA_W'($signed(thr_q[15:0]));
  assign cmp        = thr_q[30] ? (data_in < level) : (data_in > level);
  assign unused_thr = ^{thr_q[31], thr_q[29:16]};

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state      <= ST_IDLE;
      thr_q      <= '0;
      prev_cmp   <= 1'b1;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_data   <= '0;
      armed      <= 1'b0;
      done       <= 1'b0;
      trig_count <= '0;
    end else begin
      cap_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (arm && threshold[31]) begin
            state    <= ST_ARMED;
            thr_q    <= threshold;
            prev_cmp <= 1'b1;
            done     <= 1'b0;
            armed    <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (data_valid) begin
            prev_cmp <= cmp;
            // Edge, not level: a sample already past the level at arm time never fires.
            if (cmp && !prev_cmp) begin
              state    <= ST_CAPTURE;
              armed    <= 1'b0;
              cap_we   <= 1'b1;
              cap_addr <= '0;
              cap_data <= data_in;
              if (trig_count != 16'hFFFF) begin
                trig_count <= trig_count + 16'd1;
              end
            end
          end
        end
        ST_CAPTURE: begin
          if (cap_we && cap_addr == ADDR_LAST) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            cap_addr <= '0;
          end else if (data_valid) begin
            cap_we   <= 1'b1;
            cap_addr <= cap_addr + ADDR_ONE;
            cap_data <= data_in;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chan_550_threshold_trigger.sv
// Bench for chan_550_threshold_trigger: directed vector table, capture scenarios, randomized run vs reference model.
module tb_chan_550_threshold_trigger;

  localparam int DATA_W  = 16;
  localparam int CAP_AW  = 10;
  localparam int CAP_LEN = 1 << CAP_AW;

  logic              user_clk;
  logic              user_rst_n;
  logic [31:0]       threshold;
  logic              arm;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              cap_we;
  logic [CAP_AW-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic              armed;
  logic              done;
  logic [15:0]       trig_count;

  chan_550_threshold_trigger #(.DATA_W(DATA_W), .CAP_AW(CAP_AW)) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .threshold  (threshold),
    .arm        (arm),
    .data_in    (data_in),
    .data_valid (data_valid),
    .cap_we     (cap_we),
    .cap_addr   (cap_addr),
    .cap_data   (cap_data),
    .armed      (armed),
    .done       (done),
    .trig_count (trig_count)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase 0 idle, 1 waiting for crossing, 2 capturing, 3 finished.
  int          m_phase;
  int          m_level;
  bit          m_falling;
  bit          m_was_beyond;
  int          m_written;
  int          m_triggers;
  logic        e_we;
  int          e_addr;
  logic [15:0] e_data;
  logic        e_done;

  int          wr_cnt;
  logic [15:0] first_wr;
  logic [15:0] ramp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic a, input logic [31:0] t, input logic v,
                       input logic [15:0] d, input logic r);
    int  s;
    bit  beyond;
    s = int'($signed(d));
    if (!r) begin
      m_phase = 0; m_level = 0; m_falling = 0; m_was_beyond = 1;
      m_written = 0; m_triggers = 0;
      e_we = 0; e_addr = 0; e_data = '0; e_done = 0;
    end else if (m_phase == 0 || m_phase == 3) begin
      e_we = 0;
      if (a && t[31]) begin
        m_phase = 1; m_level = int'($signed(t[15:0])); m_falling = t[30];
        m_was_beyond = 1; e_done = 0;
      end
    end else if (m_phase == 1) begin
      e_we = 0;
      if (v) begin
        beyond = m_falling ? (s < m_level) : (s > m_level);
        if (beyond && !m_was_beyond) begin
          m_phase = 2; m_written = 1;
          e_we = 1; e_addr = 0; e_data = d;
          if (m_triggers < 65535) m_triggers++;
        end
        m_was_beyond = beyond;
      end
    end else begin
      if (m_written == CAP_LEN) begin
        m_phase = 3; e_done = 1; e_we = 0; e_addr = 0;
      end else if (v) begin
        e_we = 1; e_addr = m_written; e_data = d; m_written++;
      end else begin
        e_we = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("cap_we", {31'd0, cap_we}, {31'd0, e_we});
    chk("cap_addr", {22'd0, cap_addr}, e_addr);
    chk("cap_data", {16'd0, cap_data}, {16'd0, e_data});
    chk("armed", {31'd0, armed}, {31'd0, (m_phase == 1)});
    chk("done", {31'd0, done}, {31'd0, e_done});
    chk("trig_count", {16'd0, trig_count}, m_triggers);
    if (cap_we === 1'b1) begin
      wr_cnt++;
      if (cap_addr == '0) first_wr = cap_data;
    end
  endtask

  task automatic step(input logic a, input logic [31:0] t, input logic v,
                      input logic [15:0] d, input logic r);
    arm = a; threshold = t; data_valid = v; data_in = d; user_rst_n = r;
    @(posedge user_clk);
    model(a, t, v, d, r);
    #1;
    check_all();
  endtask

  task automatic run_capture(input bit gapped, input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) begin
      step(1'b0, 32'h8000_0100, gapped ? i[0] : 1'b1, ramp, 1'b1);
      ramp = ramp + 16'd1;
    end
    chk("capture_done_reached", {31'd0, done}, 32'd1);
  endtask

  typedef struct {
    logic        rst_n;
    logic        arm;
    logic [31:0] thr;
    logic        dv;
    logic [15:0] din;
    logic        e_armed;
    logic        e_done;
    logic        e_we;
    logic [15:0] e_trig;
  } vec_t;

  vec_t vt[13];

  initial begin
    logic [31:0] t;
    logic [15:0] d;
    int          snap;

    arm = 0; threshold = '0; data_valid = 0; data_in = '0; user_rst_n = 0;
    wr_cnt = 0; first_wr = '0; ramp = '0;
    model(1'b0, '0, 1'b0, '0, 1'b0);

    // rst, arm, thr, dv, din | armed, done, we, trig
    vt[0]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[1]  = '{1'b1, 1'b1, 32'h0000_0100, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[2]  = '{1'b1, 1'b1, 32'h8000_0100, 1'b1, 16'h0200, 1'b1, 1'b0, 1'b0, 16'd0};
    vt[3]  = '{1'b1, 1'b0, 32'h8000_0100, 1'b1, 16'h0300, 1'b1, 1'b0, 1'b0, 16'd0};
    vt[4]  = '{1'b1, 1'b0, 32'h8000_7000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0};
    vt[5]  = '{1'b1, 1'b0, 32'h8000_7000, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b1, 16'd1};
    vt[6]  = '{1'b1, 1'b1, 32'h8000_0100, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b1, 16'd1};
    vt[7]  = '{1'b1, 1'b0, 32'h8000_0100, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0, 16'd1};
    vt[8]  = '{1'b0, 1'b0, 32'h8000_0100, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[9]  = '{1'b1, 1'b1, 32'h8000_0100, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0};
    vt[10] = '{1'b1, 1'b0, 32'h8000_0100, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0};
    vt[11] = '{1'b1, 1'b1, 32'h8000_0100, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b1, 16'd1};
    vt[12] = '{1'b0, 1'b0, 32'h8000_0100, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b0, 16'd0};

    for (int i = 0; i < 13; i++) begin
      step(vt[i].arm, vt[i].thr, vt[i].dv, vt[i].din, vt[i].rst_n);
      chk($sformatf("vec%0d_armed", i), {31'd0, armed}, {31'd0, vt[i].e_armed});
      chk($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, vt[i].e_done});
      chk($sformatf("vec%0d_we", i), {31'd0, cap_we}, {31'd0, vt[i].e_we});
      chk($sformatf("vec%0d_trig", i), {16'd0, trig_count}, {16'd0, vt[i].e_trig});
    end

    // Basic rising trigger over a ramp.
    step(0, '0, 0, '0, 0);
    wr_cnt = 0; first_wr = 16'hDEAD;
    step(1, 32'h8000_0100, 0, '0, 1);
    for (int v = 16'h00F0; v <= 16'h0110; v++) step(0, 32'h8000_0100, 1, v[15:0], 1);
    ramp = 16'h0111;
    run_capture(1'b0, 1200);
    chk("basic_first_sample", {16'd0, first_wr}, 32'h0101);
    chk("basic_write_count", wr_cnt, CAP_LEN);
    chk("basic_trig_count", {16'd0, trig_count}, 32'd1);

    // Arm while the input is already above the level.
    wr_cnt = 0;
    step(1, 32'h8000_0100, 1, 16'h0200, 1);
    chk("pre_done_cleared", {31'd0, done}, 32'd0);
    repeat (3) step(0, 32'h8000_0100, 1, 16'h0200, 1);
    chk("pre_no_trigger", {31'd0, armed}, 32'd1);
    step(0, 32'h8000_0100, 1, 16'h0000, 1);
    step(0, 32'h8000_0100, 1, 16'h0200, 1);
    chk("pre_trigger_we", {31'd0, cap_we}, 32'd1);
    chk("pre_trigger_data", {16'd0, cap_data}, 32'h0200);
    run_capture(1'b0, 1200);
    chk("pre_write_count", wr_cnt, CAP_LEN);

    // Falling sense, level -256.
    wr_cnt = 0; first_wr = 16'hDEAD;
    step(1, 32'hC000_FF00, 0, '0, 1);
    for (int k = 0; k <= 32; k++) begin
      d = 16'(-16 * k);
      step(0, 32'hC000_FF00, 1, d, 1);
    end
    ramp = 16'h0000;
    run_capture(1'b0, 1200);
    chk("fall_first_sample", {16'd0, first_wr}, 32'hFEF0);
    chk("fall_write_count", wr_cnt, CAP_LEN);
    chk("fall_trig_count", {16'd0, trig_count}, 32'd3);

    // Gapped valid with an arm attempt mid-capture.
    wr_cnt = 0;
    step(1, 32'h8000_0100, 0, '0, 1);
    step(0, 32'h8000_0100, 1, 16'h0000, 1);
    step(0, 32'h8000_0100, 1, 16'h0300, 1);
    repeat (6) step(0, 32'h8000_0100, 1, 16'h0011, 1);
    step(1, 32'h8000_0100, 1, 16'h0400, 1);
    chk("arm_in_capture_armed", {31'd0, armed}, 32'd0);
    chk("arm_in_capture_addr", {22'd0, cap_addr}, 32'd7);
    ramp = 16'h1000;
    run_capture(1'b1, 2400);
    chk("gap_write_count", wr_cnt, CAP_LEN);
    chk("gap_trig_count", {16'd0, trig_count}, 32'd4);

    // Reset at write 500.
    wr_cnt = 0;
    step(1, 32'h8000_0100, 0, '0, 1);
    step(0, 32'h8000_0100, 1, 16'h0000, 1);
    step(0, 32'h8000_0100, 1, 16'h0200, 1);
    for (int i = 0; i < 1200 && wr_cnt < 500; i++) step(0, 32'h8000_0100, 1, 16'h0123, 1);
    chk("rst_reached_500", wr_cnt, 32'd500);
    step(0, 32'h8000_0100, 1, 16'h0200, 0);
    chk("rst_we", {31'd0, cap_we}, 32'd0);
    chk("rst_addr", {22'd0, cap_addr}, 32'd0);
    chk("rst_data", {16'd0, cap_data}, 32'd0);
    chk("rst_armed", {31'd0, armed}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_trig", {16'd0, trig_count}, 32'd0);
    snap = wr_cnt;
    for (int i = 0; i < 20; i++) step(0, 32'h8000_0100, 1, i[0] ? 16'h0200 : 16'h0000, 1);
    chk("rst_no_writes", wr_cnt, snap);
    chk("rst_trig_after", {16'd0, trig_count}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 9000; i++) begin
      t = $urandom;
      t[31] = ($urandom_range(0, 7) != 0);
      t[15:0] = 16'($urandom_range(0, 255)) - 16'd128;
      d = 16'($urandom_range(0, 511)) - 16'd256;
      step(($urandom_range(0, 15) == 0), t, ($urandom_range(0, 3) != 0), d,
           ($urandom_range(0, 2999) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chan_550_threshold_trigger.md
CHAN_550_THRESHOLD_TRIGGER -- requirements
Module: chan_550_threshold_trigger

Interface
REQ-001 Parameters, one per line:
- DATA_W, 16, signed sample width.
- CAP_AW, 10, capture address width; capture length is 2^CAP_AW samples.
REQ-002 Ports, one per line:
- user_clk  in  1  single clock; all logic on rising edge.
- user_rst_n  in  1  reset, synchronous, active-low.
- threshold  in  32  software threshold word from the capture_threshold register: [15:0] signed level; [30] trigger sense (0 = rising, 1 = falling); [31] enable.
- arm  in  1  single-cycle arm request.
- data_in  in  DATA_W  signed channel sample.
- data_valid  in  1  data_in qualifier.
- cap_we  out  1  capture buffer write enable.
- cap_addr  out  CAP_AW  capture buffer write address.
- cap_data  out  DATA_W  capture buffer write data.
- armed  out  1  high in ARMED state.
- done  out  1  capture complete, held until next arm.
- trig_count  out  16  saturating count of accepted triggers.

Function
REQ-003 The block SHALL implement four states: IDLE, ARMED, CAPTURE, DONE.
REQ-004 Arming:
- In IDLE or DONE, when arm=1 and threshold[31]=1, the block SHALL move to ARMED next cycle.
- On that transition it SHALL latch threshold into an internal register and clear done.
- arm with threshold[31]=0 SHALL be ignored.
REQ-005 In ARMED, the comparison SHALL use the latched threshold only. Later changes to the threshold input SHALL have no effect until the next arm.
REQ-006 Comparison flag cmp, evaluated on valid samples only:
- Rising sense: cmp = (data_in > level), signed compare at DATA_W.
- Falling sense: cmp = (data_in < level).
REQ-007 Trigger condition:
- A trigger SHALL occur on a valid sample where cmp=1 and the previous valid sample's cmp=0 (crossing, not level).
- The previous-cmp register SHALL be forced to 1 when entering ARMED, so a signal already beyond the level at arm time does not trigger.
REQ-008 Trigger response:
- The block SHALL move ARMED to CAPTURE.
- The triggering sample SHALL be written to address 0 in the same cycle (cap_we=1, cap_addr=0, cap_data=data_in, registered outputs, 1-cycle latency).
- trig_count SHALL increment, saturating at 16'hFFFF.
REQ-009 In CAPTURE, each valid sample SHALL produce one write at the next sequential address. Invalid cycles SHALL produce cap_we=0 with the address held.
REQ-010 When the write at address 2^CAP_AW-1 completes, the block SHALL enter DONE and assert done. cap_addr SHALL wrap to 0 and cap_we SHALL deassert.
REQ-011 arm asserted in ARMED or CAPTURE SHALL be ignored. A capture in progress is never restarted.
REQ-012 A trigger and arm on the same cycle in ARMED SHALL be treated as a trigger only.
REQ-013 In DONE, samples SHALL be ignored. done SHALL stay high until a valid arm (REQ-004).
REQ-014 armed SHALL equal (state==ARMED), registered.
REQ-015 cap_we SHALL never assert outside CAPTURE, including the trigger cycle as defined in REQ-008.

Reset
REQ-016 With user_rst_n=0 at a rising edge:
- state SHALL become IDLE.
- cap_we=0, cap_addr=0, cap_data=0, armed=0, done=0, trig_count=0.
- latched threshold=0, previous-cmp=1.
REQ-017 Reset asserted mid-capture SHALL abort the capture with no further writes. After release the block SHALL wait in IDLE for arm.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Basic rising trigger: threshold=0x8000_0100, arm, data ramp 0x00F0..0x0110 with valid every cycle -> trigger on 0x0101, cap_addr 0 holds 0x0101, 1024 writes, then done=1, trig_count=1.
- Pre-exceeded input: arm while data=0x0200 (level 0x0100) -> no trigger. Data drops to 0x0000 then rises to 0x0200 -> trigger on the rising sample.
- Falling sense: threshold=0xC000_FF00 (level -256), data 0x0000 down to 0xFE00 -> trigger on the first sample below -256.
- Gapped valid: data_valid toggling 1/0 during CAPTURE -> addresses contiguous, exactly 1024 writes, done after the 1024th valid sample.
- Ignored events: arm during CAPTURE -> no restart. Threshold change while ARMED -> old level still used. arm with bit31=0 -> remains IDLE.
- Reset at write 500 of a capture -> all outputs 0 next cycle, no writes until re-arm, trig_count=0.
